alu_arb: RTL and testbench



---
 rtl/alu_arb_if.sv | 57 +++++
 rtl/alu_arb.sv | 124 ++++++++++++
 tb/tb_alu_arb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters and ALU).
interface alu_arb_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int SH_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic [SH_W-1:0]   req0_shamt;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic [SH_W-1:0]   req1_shamt;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        rsp_flags;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [SH_W-1:0]   alu_shamt;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        alu_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_shamt,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, req1_shamt,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op, alu_shamt,
        input  alu_out, alu_flags
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_shamt,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op, req1_shamt,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op, alu_shamt,
        output alu_out, alu_flags
    );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter/sequencer for the shared registered ALU; round-robin by default,
// fixed priority (requester 0 first) when ALU_ARB_PRIO_EN is defined.
//
// state | meaning
// IDLE  | grant offered; operands latched into alu_* on handshake
// EXEC  | ALU registers its result at the end of this cycle
// CAPT  | alu_out/alu_flags captured into the response registers
// RESP  | response held until the owner takes it
module alu_arb #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int SH_W   = 4
) (
    input  logic     clk,
    input  logic     rst,
    alu_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [SH_W-1:0]   alu_shamt_q, alu_shamt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;

    logic gnt_any;
    logic gnt_sel;
    logic accept;
    logic owner_ready;

    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
`ifdef ALU_ARB_PRIO_EN
        gnt_sel = ~bus.req0_valid;
`else
        gnt_sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
`endif
        // Ready is combinational, so it must also be forced low while reset is held.
        accept      = (state_q == IDLE) & gnt_any & ~rst;
        owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rsp_valid_d  = rsp_valid_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_shamt_d  = alu_shamt_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d      = gnt_sel ? bus.req1_a     : bus.req0_a;
                    alu_b_d      = gnt_sel ? bus.req1_b     : bus.req0_b;
                    alu_op_d     = gnt_sel ? bus.req1_op    : bus.req0_op;
                    alu_shamt_d  = gnt_sel ? bus.req1_shamt : bus.req0_shamt;
                    owner_d      = gnt_sel;
                    last_grant_d = gnt_sel;
                    state_d      = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                rsp_data_d  = bus.alu_out;
                rsp_flags_d = bus.alu_flags;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_shamt_q  <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_shamt_q  <= alu_shamt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.req0_ready = accept & ~gnt_sel;
    assign bus.req1_ready = accept & gnt_sel;
    assign bus.rsp0_valid = rsp_valid_q & ~owner_q;
    assign bus.rsp1_valid = rsp_valid_q & owner_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_shamt  = alu_shamt_q;
endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: stub registered ALU, transaction-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_arb;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_LSL = 3'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] flag_cfg = 4'h0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_arb_if bus ();
    alu_arb u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [3:0] sh);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_LSL:  return a << sh;
            default: return a ^ b;
        endcase
    endfunction

    // Stand-in for the external ALU: registered result; flags come from the bench.
    always_ff @(posedge clk) begin
        bus.alu_out   <= alu_ref(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_shamt);
        bus.alu_flags <= flag_cfg;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic       m_busy, m_own, m_lg, g, e_r0, e_r1;
    int         m_age;
    logic [7:0] m_a, m_b, m_d;
    logic [2:0] m_op;
    logic [3:0] m_sh, m_f;
    int         grant_q[$];
    int         acc_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            chk("rst req0_ready", bus.req0_ready, 0);
            chk("rst req1_ready", bus.req1_ready, 0);
            chk("rst rsp0_valid", bus.rsp0_valid, 0);
            chk("rst rsp1_valid", bus.rsp1_valid, 0);
            chk("rst rsp_data", bus.rsp_data, 0);
            chk("rst rsp_flags", bus.rsp_flags, 0);
            chk("rst alu_a", bus.alu_a, 0);
            chk("rst alu_b", bus.alu_b, 0);
            chk("rst alu_op", bus.alu_op, 0);
            chk("rst alu_shamt", bus.alu_shamt, 0);
            m_busy = 0; m_age = 0; m_own = 0; m_lg = 1;
            m_a = 0; m_b = 0; m_op = 0; m_sh = 0;
        end else begin
`ifdef ALU_ARB_PRIO_EN
            g = (bus.req0_valid && bus.req1_valid) ? 1'b0 : bus.req1_valid;
`else
            g = (bus.req0_valid && bus.req1_valid) ? ~m_lg : bus.req1_valid;
`endif
            e_r0 = !m_busy && bus.req0_valid && !g;
            e_r1 = !m_busy && bus.req1_valid && g;
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("rsp0_valid", bus.rsp0_valid, m_busy && m_age == 2 && !m_own);
            chk("rsp1_valid", bus.rsp1_valid, m_busy && m_age == 2 && m_own);
            chk("alu_a", bus.alu_a, m_a);
            chk("alu_b", bus.alu_b, m_b);
            chk("alu_op", bus.alu_op, m_op);
            chk("alu_shamt", bus.alu_shamt, m_sh);
            if (m_busy && m_age == 2) begin
                chk("rsp_data", bus.rsp_data, m_d);
                chk("rsp_flags", bus.rsp_flags, m_f);
            end
            if (m_busy) begin
                if (m_age < 2) m_age++;
                else if (m_own ? bus.rsp1_ready : bus.rsp0_ready) m_busy = 0;
            end else if (e_r0 || e_r1) begin
                grant_q.push_back(int'(g));
                acc_cyc.push_back(cyc);
                m_busy = 1; m_age = 0; m_own = g; m_lg = g;
                m_a  = g ? bus.req1_a     : bus.req0_a;
                m_b  = g ? bus.req1_b     : bus.req0_b;
                m_op = g ? bus.req1_op    : bus.req0_op;
                m_sh = g ? bus.req1_shamt : bus.req0_shamt;
                m_d  = alu_ref(m_op, m_a, m_b, m_sh);
                m_f  = flag_cfg;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int r, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] sh);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_shamt = sh;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_shamt = sh;
        end
    endtask

    // Single op on an idle arbiter with the owner's rsp_ready already high.
    task automatic run_op(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sh, input logic [3:0] fl, input logic [7:0] exp_d,
                          input string nm);
        flag_cfg = fl;
        set_req(r, 1'b1, op, a, b, sh);
        @(negedge clk);
        chk({nm, " ready same cycle"}, r ? bus.req1_ready : bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(r, 1'b0, op, a, b, sh);
        @(negedge clk);
        chk({nm, " alu_op after accept"}, bus.alu_op, op);
        chk({nm, " alu_shamt after accept"}, bus.alu_shamt, sh);
        chk({nm, " rsp not yet valid"}, r ? bus.rsp1_valid : bus.rsp0_valid, 0);
        @(negedge clk);
        chk({nm, " rsp not yet valid 2"}, r ? bus.rsp1_valid : bus.rsp0_valid, 0);
        @(negedge clk);
        chk({nm, " rsp valid at +2"}, r ? bus.rsp1_valid : bus.rsp0_valid, 1);
        chk({nm, " rsp_data"}, bus.rsp_data, exp_d);
        chk({nm, " rsp_flags"}, bus.rsp_flags, fl);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic stream(input int r);
        int n = 0;
        logic acc;
        set_req(r, 1'b1, OP_SUB, 8'h00, 8'h01, 4'h0);
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clk);
            acc = r ? bus.req1_ready : bus.req0_ready;
            @(posedge clk); #1;
            if (acc) n++;
        end
        set_req(r, 1'b0, OP_SUB, 8'h00, 8'h01, 4'h0);
        chk("t3 ops accepted", n, 4);
    endtask

    int exp_order[8];
    logic got;

    initial begin
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0);
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00, 4'h0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T1: ADD 7F+01
        run_op(0, OP_ADD, 8'h7F, 8'h01, 4'h0, 4'b1000, 8'h80, "t1 add");

        // T2: req1 held response, req0 waits
        bus.rsp1_ready = 1'b0;
        flag_cfg = 4'b0111;
        set_req(1, 1'b1, OP_ADD, 8'hFF, 8'h01, 4'h0);
        @(negedge clk);
        chk("t2 req1_ready", bus.req1_ready, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, OP_ADD, 8'hFF, 8'h01, 4'h0);
        set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02, 4'h0);
        repeat (2) begin
            @(negedge clk);
            chk("t2 req0_ready busy", bus.req0_ready, 0);
        end
        repeat (5) begin
            @(negedge clk);
            chk("t2 rsp1_valid held", bus.rsp1_valid, 1);
            chk("t2 rsp_data held", bus.rsp_data, 8'h00);
            chk("t2 rsp_flags held", bus.rsp_flags, 4'b0111);
            chk("t2 req0_ready held", bus.req0_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = bus.req0_ready;
        end
        chk("t2 req0 served after release", got, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_ADD, 8'h01, 8'h02, 4'h0);
        repeat (4) @(posedge clk);
        #1;

        // T3: both streaming 4 SUB ops
        pulse_reset();
        flag_cfg = 4'b1011;
        grant_q.delete();
        acc_cyc.delete();
        fork
            stream(0);
            stream(1);
        join
        repeat (6) @(posedge clk);
        #1;
`ifdef ALU_ARB_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        chk("t3 grant count", grant_q.size(), 8);
        for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk($sformatf("t3 grant order %0d", i), grant_q[i], exp_order[i]);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk($sformatf("t3 issue interval %0d", i), acc_cyc[i] - acc_cyc[i-1], 4);

        // T4: reset while in EXEC
        flag_cfg = 4'b0001;
        set_req(0, 1'b1, OP_ADD, 8'h10, 8'h20, 4'h3);
        @(negedge clk);
        chk("t4 accept", bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, OP_ADD, 8'h10, 8'h20, 4'h3);
        #2 rst = 1'b1;
        #1;
        chk("t4 async alu_a", bus.alu_a, 0);
        chk("t4 async alu_shamt", bus.alu_shamt, 0);
        chk("t4 async rsp0_valid", bus.rsp0_valid, 0);
        chk("t4 async rsp_flags", bus.rsp_flags, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t4 no rsp0 after reset", bus.rsp0_valid, 0);
            chk("t4 no rsp1 after reset", bus.rsp1_valid, 0);
        end
        @(posedge clk); #1;
        run_op(0, OP_ADD, 8'h10, 8'h20, 4'h3, 4'b0001, 8'h30, "t4 reissue");

        // T5: LSL
        run_op(0, OP_LSL, 8'h81, 8'h00, 4'h1, 4'b0111, 8'h02, "t5 lsl");
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
